// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: hunts for a sync word, assembles a data word,
// checks optional parity and hands the word to a one-entry output buffer.
module serial_frame_receiver #(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    SYNC_WIDTH      = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN    = 8'hA5,
    parameter string                 PARITY          = "EVEN",
    parameter string                 SHIFT_DIRECTION = "LEFT"
) (
    input  logic                  i_clock,
    input  logic                  i_sclr,
    input  logic                  i_enable,
    input  logic                  i_serial_in,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_parity_err,
    output logic                  o_out_valid,
    output logic                  o_overrun,
    output logic                  o_sync_lock
);

    localparam bit HAS_PAR = (PARITY != "NONE");
    localparam bit ODD_PAR = (PARITY == "ODD");
    localparam bit SHR     = (SHIFT_DIRECTION == "RIGHT");
    localparam int HW      = $clog2(SYNC_WIDTH + 1);
    localparam int DW      = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_HUNT,
        S_DATA,
        S_PAR
    } state_t;

    state_t                  r_state;
    logic [SYNC_WIDTH-1:0]   r_window;
    logic [HW-1:0]           r_hcnt;
    logic [DW-1:0]           r_dcnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_xor;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_err;
    logic                    r_valid;
    logic                    r_overrun;

    state_t                  w_state_nxt;
    logic [SYNC_WIDTH-1:0]   w_win_nxt;
    logic [DATA_WIDTH-1:0]   w_shift_nxt;
    logic [DATA_WIDTH-1:0]   w_word;
    logic                    w_word_err;
    logic                    w_done;
    logic                    w_match;
    logic                    w_last;
    logic                    w_bit_xor;

    assign w_win_nxt = {r_window[SYNC_WIDTH-2:0], i_serial_in};
    assign w_shift_nxt = SHR ? {i_serial_in, r_shift[DATA_WIDTH-1:1]}
                             : {r_shift[DATA_WIDTH-2:0], i_serial_in};
    // Hunt count including the current bit must reach SYNC_WIDTH
    assign w_match = (r_hcnt >= HW'(SYNC_WIDTH - 1)) &&
                     (w_win_nxt == SYNC_PATTERN);
    assign w_last    = (r_dcnt == DW'(DATA_WIDTH - 1));
    assign w_bit_xor = r_xor ^ i_serial_in;

    always_ff @(posedge i_clock) begin
        if (i_sclr) r_state <= S_HUNT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_word      = w_shift_nxt;
        w_word_err  = 1'b0;
        unique case (r_state)
            S_HUNT: begin
                if (i_enable && w_match) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (i_enable && w_last) begin
                    if (HAS_PAR) begin
                        w_state_nxt = S_PAR;
                    end else begin
                        w_state_nxt = S_HUNT;
                        w_done      = 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (i_enable) begin
                    w_state_nxt = S_HUNT;
                    w_done      = 1'b1;
                    w_word      = r_shift;
                    w_word_err  = w_bit_xor ^ ODD_PAR;
                end
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_sclr) begin
            r_window  <= '0;
            r_hcnt    <= '0;
            r_dcnt    <= '0;
            r_shift   <= '0;
            r_xor     <= 1'b0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_enable && r_state == S_HUNT) begin
                if (w_match) begin
                    r_window <= '0;
                    r_hcnt   <= '0;
                    r_dcnt   <= '0;
                    r_xor    <= 1'b0;
                end else begin
                    r_window <= w_win_nxt;
                    if (r_hcnt != HW'(SYNC_WIDTH)) r_hcnt <= r_hcnt + 1'b1;
                end
            end else if (i_enable && r_state == S_DATA) begin
                r_shift <= w_shift_nxt;
                r_xor   <= w_bit_xor;
                r_dcnt  <= w_last ? '0 : r_dcnt + 1'b1;
            end
            // A full buffer that is not draining drops the new word
            if (w_done && (!r_valid || i_out_ready)) begin
                r_data  <= w_word;
                r_err   <= w_word_err;
                r_valid <= 1'b1;
            end else if (r_valid && i_out_ready) begin
                r_valid <= 1'b0;
            end
            r_overrun <= w_done && r_valid && !i_out_ready;
        end
    end

    assign o_out_data       = r_data;
    assign o_out_parity_err = r_err;
    assign o_out_valid      = r_valid;
    assign o_overrun        = r_overrun;
    assign o_sync_lock      = (r_state == S_DATA) || (r_state == S_PAR);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: LEFT/EVEN and RIGHT/NONE
// instances, directed frames, monitor pops expected words on handshakes.
module tb_serial_frame_receiver;

    logic       clk = 1'b0;
    logic       sclr;
    logic       en, ser, rdy;
    logic       r_en, r_ser, r_rdy;
    logic [7:0] dat, r_dat;
    logic       perr, valid, ovr, lock;
    logic       r_perr, r_valid, r_ovr, r_lock;

    int n_pass  = 0;
    int n_total = 0;
    int ovr_cnt = 0;
    int lock_cnt;

    logic [8:0] q[$];
    logic [8:0] q_r[$];

    always #5 clk = ~clk;

    serial_frame_receiver #(
        .DATA_WIDTH(8), .SYNC_WIDTH(8), .SYNC_PATTERN(8'hA5),
        .PARITY("EVEN"), .SHIFT_DIRECTION("LEFT")
    ) u_dut (
        .i_clock(clk), .i_sclr(sclr), .i_enable(en),
        .i_serial_in(ser), .i_out_ready(rdy),
        .o_out_data(dat), .o_out_parity_err(perr),
        .o_out_valid(valid), .o_overrun(ovr), .o_sync_lock(lock)
    );

    serial_frame_receiver #(
        .DATA_WIDTH(8), .SYNC_WIDTH(8), .SYNC_PATTERN(8'hA5),
        .PARITY("NONE"), .SHIFT_DIRECTION("RIGHT")
    ) u_r (
        .i_clock(clk), .i_sclr(sclr), .i_enable(r_en),
        .i_serial_in(r_ser), .i_out_ready(r_rdy),
        .o_out_data(r_dat), .o_out_parity_err(r_perr),
        .o_out_valid(r_valid), .o_overrun(r_ovr), .o_sync_lock(r_lock)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!sclr) begin
            if (ovr) ovr_cnt++;
            if (valid && rdy) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", {23'd0, perr, dat}, 32'hFFFF);
                end else begin
                    logic [8:0] e;
                    e = q.pop_front();
                    chk("data", {24'd0, dat}, {24'd0, e[7:0]});
                    chk("parity_err", {31'd0, perr}, {31'd0, e[8]});
                end
            end
            if (r_valid && r_rdy) begin
                if (q_r.size() == 0) begin
                    chk("r_unexpected", {23'd0, r_perr, r_dat}, 32'hFFFF);
                end else begin
                    logic [8:0] e;
                    e = q_r.pop_front();
                    chk("r_data", {24'd0, r_dat}, {24'd0, e[7:0]});
                    chk("r_parity_err", {31'd0, r_perr}, {31'd0, e[8]});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic e);
        ser = b;
        en  = e;
        step();
        if (lock) lock_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i], 1'b1);
            if (gap) send_bit(~v[i], 1'b0);
        end
    endtask

    task automatic send_frame(input logic [7:0] v, input logic p, input bit gap);
        send_byte(8'hA5, gap);
        send_byte(v, gap);
        send_bit(p, 1'b1);
        en = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        chk(name, q.size(), 0);
    endtask

    initial begin
        sclr = 1'b1; en = 1'b0; ser = 1'b0; rdy = 1'b1;
        r_en = 1'b0; r_ser = 1'b0; r_rdy = 1'b1;
        step();
        sclr = 1'b0;
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_data", {24'd0, dat}, 0);
        chk("rst_perr", {31'd0, perr}, 0);
        chk("rst_ovr", {31'd0, ovr}, 0);
        chk("rst_lock", {31'd0, lock}, 0);
        chk("rst_r_valid", {31'd0, r_valid}, 0);

        // 1: good even-parity frame
        lock_cnt = 0;
        q.push_back({1'b0, 8'hDB});
        send_frame(8'hDB, 1'b0, 1'b0);
        chk("t1_lock_bits", lock_cnt, 9);
        drain("t1_drain");

        // 2: wrong parity bit
        q.push_back({1'b1, 8'hDB});
        send_frame(8'hDB, 1'b1, 1'b0);
        drain("t2_drain");

        // 3: noise then sync, enable toggling
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0);
        q.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b1);
        drain("t3_drain");
        chk("t3_no_ovr", ovr_cnt, 0);

        // 4: overrun with stalled consumer
        rdy = 1'b0;
        q.push_back({1'b0, 8'h11});
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        chk("t4_hold_data", {24'd0, dat}, 32'h11);
        chk("t4_hold_valid", {31'd0, valid}, 1);
        step(); step();
        chk("t4_ovr_once", ovr_cnt, 1);
        rdy = 1'b1;
        drain("t4_drain");
        step();
        chk("t4_valid_low", {31'd0, valid}, 0);

        // 5: RIGHT shift, no parity
        q_r.push_back({1'b0, 8'h01});
        for (int i = 15; i >= 0; i--) begin
            logic [15:0] s;
            s = 16'hA580;
            r_ser = s[i];
            r_en  = 1'b1;
            step();
        end
        r_en = 1'b0;
        for (int i = 0; i < 20 && q_r.size() != 0; i++) step();
        chk("t5_drain", q_r.size(), 0);

        // 6: reset mid-frame
        send_byte(8'hA5, 1'b0);
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
        en = 1'b0;
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        chk("t6_valid", {31'd0, valid}, 0);
        chk("t6_lock", {31'd0, lock}, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        en = 1'b0;
        step(); step(); step();
        chk("t6_lock_idle", {31'd0, lock}, 0);
        q.push_back({1'b0, 8'h5A});
        send_frame(8'h5A, 1'b0, 1'b0);
        drain("t6_drain");
        chk("final_ovr", ovr_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
Downstream consumer of the parameterised shift register's serial `shiftout` stream. It hunts for a sync pattern in the bitstream, then assembles the next DATA_WIDTH bits into a word. An optional parity bit follows the data and is checked. The finished word is presented on a one-entry valid/ready output buffer to the next stage.

Parameters:
DATA_WIDTH, 8, width of the assembled data word (>=2)
SYNC_WIDTH, 8, length of the sync pattern in bits (>=2)
SYNC_PATTERN, 8'hA5, sync word; its MSB is the first bit received on the line
PARITY, "EVEN", "EVEN" / "ODD" / "NONE"; "NONE" means no parity bit is on the line
SHIFT_DIRECTION, "LEFT", "LEFT": first data bit goes to out_data MSB; "RIGHT": first data bit goes to out_data LSB

Ports:
clock  in  1  single clock; all logic is rising-edge
sclr  in  1  reset, synchronous, active-high
enable  in  1  bit strobe; serial_in is sampled only on edges where enable=1
serial_in  in  1  serial bit, driven by the shift register's shiftout
out_ready  in  1  downstream accepts the word
out_data  out  DATA_WIDTH  assembled word
out_parity_err  out  1  parity mismatch flag for out_data; qualified by out_valid
out_valid  out  1  output buffer holds a word
overrun  out  1  one-cycle pulse: a completed frame was dropped
sync_lock  out  1  high while in DATA or PAR state

Behaviour:
- Reset: sclr=1 at an edge has priority over every other input. On that edge:
  - state=HUNT; sync window, bit counter and shift register are cleared.
  - out_data=0, out_parity_err=0, out_valid=0, overrun=0, sync_lock=0.
- Strobe gating: edges with enable=0 do not sample serial_in and do not advance the FSM or counters. The output handshake still operates on those edges.
- HUNT:
  - Each strobed bit shifts into the SYNC_WIDTH-bit window: window <= {window[SYNC_WIDTH-2:0], serial_in}.
  - A hunt counter saturates at SYNC_WIDTH.
  - Move to DATA when counter==SYNC_WIDTH and the updated window == SYNC_PATTERN. Both conditions are evaluated including the current bit, so a match takes effect on the same edge as the last sync bit.
  - At least SYNC_WIDTH bits must be received in HUNT before a match, even when SYNC_PATTERN=0.
- DATA:
  - Collect exactly DATA_WIDTH strobed bits.
  - LEFT: shift left with the new bit at LSB. RIGHT: shift right with the new bit at MSB.
  - A running XOR of the data bits is kept.
  - After the last data bit, go to PAR, or, if PARITY="NONE", complete the frame on that edge.
- PAR:
  - The next strobed bit is the parity bit.
  - EVEN: error = XOR(data bits, parity bit) != 0. ODD: error = XOR(data bits, parity bit) != 1.
  - The frame completes on this edge.
- Frame completion: return to HUNT with the window and hunt counter cleared, so every frame needs a fresh sync.
- Latency: out_valid rises on the edge that samples the last frame bit. The word is visible in the cycle after that edge.
- Output buffer:
  - out_valid && out_ready at an edge: buffer is released.
  - Completion with the buffer empty, or released on the same edge: load out_data and out_parity_err; out_valid=1, staying 1 across back-to-back words.
  - Completion with out_valid=1 and out_ready=0: the new word is discarded, the buffer is unchanged, and overrun=1 for exactly one cycle.
  - out_data and out_parity_err are stable while out_valid=1 and out_ready=0.
- Sync inside data: a sync-pattern-shaped sequence inside DATA or PAR is treated as data, never as a resync.
- sclr mid-frame: the partial word is discarded and any buffered word is dropped (out_valid=0).

Test Plan:
1. Reset, then EVEN parity, out_ready=1. Send A5 MSB-first, then 0xDB MSB-first, then parity 0 (enable=1 every cycle).
   -> out_valid pulses 1 cycle, out_data=8'hDB, out_parity_err=0, overrun=0; sync_lock high for 9 bits.
2. Same frame with parity bit 1.
   -> out_data=8'hDB, out_parity_err=1.
3. Send noise 1,1,0 then A5, 0x3C, parity 0, with enable toggling 1/0 every cycle.
   -> sync found only after the true A5; out_data=8'h3C. Cycles with enable=0 change nothing.
4. out_ready=0. Send two complete frames, 0x11 (parity 0) then 0x22 (parity 0).
   -> out_data stays 8'h11 with out_valid=1; overrun pulses once at the end of the second frame. Raising out_ready then gives one handshake, and out_valid=0 afterwards.
5. Instance with SHIFT_DIRECTION="RIGHT" and PARITY="NONE". Send A5 then bits 1,0,0,0,0,0,0,0.
   -> out_data=8'h01; out_parity_err=0.
6. Assert sclr for 1 cycle after 4 data bits of a frame.
   -> state HUNT, out_valid=0, sync_lock=0. The remaining bits do not produce a word until a new A5 arrives.
